tape_bit_decoder: RTL and testbench

// - Cassette-input decoder for the SVI-328 tape path. It is the receive-side counterpart of the square-wave tape encoder.
// - It measures the high phase of each square cycle on the comparator input and classifies it as a bit:
//   - short high (~T) = 1; long high (~2T) = 0.
// - Bits are assembled MSB-first into bytes and presented to the CPU-side cassette port with a one-cycle strobe.

---
 rtl/tape_bit_decoder.sv | 195 +++++++++++++++++++
 tb/tb_tape_bit_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_bit_decoder.sv
// Cassette-input decoder: classifies comparator high-phase lengths as bits and packs them MSB-first into bytes.
// Optional input glitch filter enabled by defining TAPE_DEC_FILTER_EN.
`timescale 1ns/1ps

module tape_bit_decoder #(
    parameter int unsigned CW        = 16,
    parameter int unsigned THRESH    = 6531,
    parameter int unsigned MIN_HIGH  = 2177,
    parameter int unsigned MAX_LEVEL = 17416,
    parameter int unsigned FILT_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tape_in,
    input  logic       extend,
    input  logic       arm,
    output logic [7:0] dout,
    output logic       valid,
    output logic       err,
    output logic       carrier
);

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam int unsigned NBW = 4;

    // The filter history needs at least two samples to be meaningful.
    if (FILT_LEN < 2) begin : g_filt_len_check
        $error("tape_bit_decoder: FILT_LEN must be at least 2");
    end

    logic          s1;
    logic          s2;
    logic          lvl;
    logic          lvl_d;
    logic [CW-1:0] cnt;

    state_t         state;
    logic [NBW-1:0] nbit;
    logic [7:0]     sr;
    logic           framed_mode;

    logic lvl_edge;
    logic fall;
    logic is_glitch;
    logic is_bit;
    logic bit_val;
    logic loss;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= tape_in;
            s2 <= s1;
        end
    end

`ifdef TAPE_DEC_FILTER_EN
    logic [FILT_LEN-1:0] hist;

    // Level changes only after FILT_LEN identical samples; short spikes never reach the edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
            lvl  <= 1'b0;
        end else begin
            hist <= {hist[FILT_LEN-2:0], s2};
            if (&hist) begin
                lvl <= 1'b1;
            end else if (~|hist) begin
                lvl <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= 1'b0;
        end else begin
            lvl <= s2;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign lvl_edge = lvl ^ lvl_d;
    assign fall     = lvl_d & ~lvl;

    // Level-duration counter; the edge cycle is the first cycle of the new level, so cnt equals the level length.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (lvl_edge) begin
            cnt <= CW'(1);
        end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Classification of the high phase that just ended, and carrier-loss detection (fires once per level).
    always_comb begin
        is_glitch = fall && (cnt < CW'(MIN_HIGH));
        is_bit    = fall && !(cnt < CW'(MIN_HIGH));
        bit_val   = cnt < CW'(THRESH);
        loss      = !lvl_edge && (cnt == CW'(MAX_LEVEL));
    end

    // Byte-assembly FSM with registered outputs; arm overrides everything, then loss, glitch, bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            nbit        <= '0;
            sr          <= '0;
            framed_mode <= 1'b0;
            dout        <= '0;
            valid       <= 1'b0;
            err         <= 1'b0;
            carrier     <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (arm) begin
                state       <= HUNT;
                nbit        <= '0;
                sr          <= '0;
                framed_mode <= 1'b0;
                carrier     <= 1'b0;
            end else if (loss) begin
                carrier <= 1'b0;
                state   <= HUNT;
                nbit    <= '0;
                sr      <= '0;
                if ((state == DATA) && ((nbit != '0) || framed_mode)) begin
                    err <= 1'b1;
                end
                framed_mode <= 1'b0;
            end else if (is_glitch) begin
                err         <= 1'b1;
                state       <= HUNT;
                nbit        <= '0;
                sr          <= '0;
                framed_mode <= 1'b0;
            end else if (is_bit) begin
                carrier <= 1'b1;
                case (state)
                    HUNT: begin
                        if (extend) begin
                            if (!bit_val) begin
                                state       <= DATA;
                                nbit        <= '0;
                                sr          <= '0;
                                framed_mode <= 1'b1;
                            end
                        end else begin
                            state       <= DATA;
                            nbit        <= NBW'(1);
                            sr          <= {7'd0, bit_val};
                            framed_mode <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (nbit == NBW'(7)) begin
                            dout  <= {sr[6:0], bit_val};
                            valid <= 1'b1;
                            nbit  <= '0;
                            sr    <= '0;
                            if (framed_mode) begin
                                state       <= HUNT;
                                framed_mode <= 1'b0;
                            end
                        end else begin
                            sr   <= {sr[6:0], bit_val};
                            nbit <= nbit + NBW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tape_bit_decoder.sv
// Directed self-checking bench for tape_bit_decoder, run with time-scaled thresholds (T = 64 clk).
`timescale 1ns/1ps

module tb_tape_bit_decoder;

    localparam int unsigned T         = 64;
    localparam int unsigned THRESH    = 96;
    localparam int unsigned MIN_HIGH  = 32;
    localparam int unsigned MAX_LEVEL = 256;
    localparam int unsigned FILT_LEN  = 4;
`ifdef TAPE_DEC_FILTER_EN
    localparam int LAT = 4 + FILT_LEN;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tape_in = 1'b0;
    logic       extend = 1'b0;
    logic       arm = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       err;
    logic       carrier;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_vcyc = 0;
    int prev_vcyc = 0;
    int last_fall = 0;
    logic [7:0] last_dout = 8'h00;
    logic [7:0] prev_dout = 8'h00;

    tape_bit_decoder #(
        .CW(16), .THRESH(THRESH), .MIN_HIGH(MIN_HIGH), .MAX_LEVEL(MAX_LEVEL), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk), .reset(reset), .tape_in(tape_in), .extend(extend), .arm(arm),
        .dout(dout), .valid(valid), .err(err), .carrier(carrier)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid   <= n_valid + 1;
            prev_dout <= last_dout;
            last_dout <= dout;
            prev_vcyc <= last_vcyc;
            last_vcyc <= cyc;
        end
        if (err) n_err <= n_err + 1;
    end

    task automatic send_level(input logic v, input int n);
        tape_in = v;
        if (!v) last_fall = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        send_level(1'b1, b ? T : 2*T);
        send_level(1'b0, b ? T : 2*T);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] b);
        repeat (4) send_bit(1'b1);
        send_bit(1'b0);
        send_byte(b);
    endtask

    task automatic send_partial();
        repeat (4) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL reset_carrier: got %b want 0", carrier); end
        reset = 1'b0;
        send_level(1'b0, 10);
    endtask

    task automatic test_framed();
        int vb, eb;
        extend = 1'b1;
        vb = n_valid; eb = n_err;
        send_frame(8'hA5);
        n_cmp++; if (n_valid - vb != 1) begin n_fail++; $display("FAIL framed_count: got %0d want 1", n_valid - vb); end
        n_cmp++; if (last_dout !== 8'hA5) begin n_fail++; $display("FAIL framed_dout: got %h want a5", last_dout); end
        n_cmp++; if (n_err != eb) begin n_fail++; $display("FAIL framed_err: got %0d want 0", n_err - eb); end
        n_cmp++; if (carrier !== 1'b1) begin n_fail++; $display("FAIL framed_carrier: got %b want 1", carrier); end
        n_cmp++; if (last_vcyc - last_fall != LAT) begin n_fail++; $display("FAIL framed_latency: got %0d want %0d", last_vcyc - last_fall, LAT); end
        send_level(1'b0, 50);
    endtask

    task automatic test_back_to_back();
        int vb, eb;
        extend = 1'b0;
        pulse_arm();
        vb = n_valid; eb = n_err;
        send_byte(8'h3C);
        send_byte(8'hFF);
        n_cmp++; if (n_valid - vb != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", n_valid - vb); end
        n_cmp++; if (prev_dout !== 8'h3C) begin n_fail++; $display("FAIL b2b_first: got %h want 3c", prev_dout); end
        n_cmp++; if (last_dout !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h want ff", last_dout); end
        // fall-to-fall: low of 0x3C LSB (2T) + seven 0xFF cells (2T each) + high of last 0xFF bit (T)
        n_cmp++; if (last_vcyc - prev_vcyc != 17*T) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", last_vcyc - prev_vcyc, 17*T); end
        n_cmp++; if (n_err != eb) begin n_fail++; $display("FAIL b2b_err: got %0d want 0", n_err - eb); end
    endtask

    task automatic test_boundary();
        int vb;
        extend = 1'b0;
        pulse_arm();
        vb = n_valid;
        send_level(1'b1, THRESH - 1);
        send_level(1'b0, THRESH - 1);
        repeat (7) send_bit(1'b0);
        n_cmp++; if (n_valid - vb != 1) begin n_fail++; $display("FAIL bound_lo_count: got %0d want 1", n_valid - vb); end
        n_cmp++; if (last_dout !== 8'h80) begin n_fail++; $display("FAIL bound_lo_dout: got %h want 80", last_dout); end
        pulse_arm();
        vb = n_valid;
        send_level(1'b1, THRESH);
        send_level(1'b0, THRESH);
        repeat (7) send_bit(1'b0);
        n_cmp++; if (n_valid - vb != 1) begin n_fail++; $display("FAIL bound_hi_count: got %0d want 1", n_valid - vb); end
        n_cmp++; if (last_dout !== 8'h00) begin n_fail++; $display("FAIL bound_hi_dout: got %h want 00", last_dout); end
    endtask

    task automatic test_glitch();
        int vb, eb;
        extend = 1'b1;
        pulse_arm();
        vb = n_valid; eb = n_err;
        send_partial();
        send_level(1'b1, 15);
        send_level(1'b0, T);
        n_cmp++; if (n_err - eb != 1) begin n_fail++; $display("FAIL glitch_err: got %0d want 1", n_err - eb); end
        n_cmp++; if (n_valid != vb) begin n_fail++; $display("FAIL glitch_novalid: got %0d want 0", n_valid - vb); end
        send_frame(8'h5A);
        n_cmp++; if (n_valid - vb != 1) begin n_fail++; $display("FAIL glitch_recover_count: got %0d want 1", n_valid - vb); end
        n_cmp++; if (last_dout !== 8'h5A) begin n_fail++; $display("FAIL glitch_recover_dout: got %h want 5a", last_dout); end
    endtask

    task automatic test_loss();
        int vb, eb;
        extend = 1'b1;
        send_level(1'b0, 400);
        vb = n_valid; eb = n_err;
        send_partial();
        send_level(1'b0, 300);
        n_cmp++; if (n_err - eb != 1) begin n_fail++; $display("FAIL loss_err: got %0d want 1", n_err - eb); end
        n_cmp++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL loss_carrier: got %b want 0", carrier); end
        n_cmp++; if (n_valid != vb) begin n_fail++; $display("FAIL loss_novalid: got %0d want 0", n_valid - vb); end
        send_level(1'b0, 500);
        n_cmp++; if (n_err - eb != 1) begin n_fail++; $display("FAIL loss_no_repeat: got %0d want 1", n_err - eb); end
    endtask

    task automatic test_reset_mid();
        int vb;
        extend = 1'b1;
        send_partial();
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout: got %h want 00", dout); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err); end
        n_cmp++; if (carrier !== 1'b0) begin n_fail++; $display("FAIL rstmid_carrier: got %b want 0", carrier); end
        reset = 1'b0;
        send_level(1'b0, 20);
        vb = n_valid;
        send_frame(8'h69);
        n_cmp++; if (n_valid - vb != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", n_valid - vb); end
        n_cmp++; if (last_dout !== 8'h69) begin n_fail++; $display("FAIL rstmid_dout2: got %h want 69", last_dout); end
    endtask

    task automatic test_filter();
        int vb, eb;
        logic [7:0] b;
        int h;
        extend = 1'b1;
        send_level(1'b0, 20);
        vb = n_valid; eb = n_err;
        b = 8'hC3;
        repeat (4) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) begin
            h = b[i] ? T : 2*T;
            send_level(1'b1, 15);
            send_level(1'b0, 2);
            send_level(1'b1, h - 17);
            send_level(1'b0, h);
        end
`ifdef TAPE_DEC_FILTER_EN
        n_cmp++; if (n_valid - vb != 1) begin n_fail++; $display("FAIL filter_count: got %0d want 1", n_valid - vb); end
        n_cmp++; if (last_dout !== 8'hC3) begin n_fail++; $display("FAIL filter_dout: got %h want c3", last_dout); end
        n_cmp++; if (n_err != eb) begin n_fail++; $display("FAIL filter_err: got %0d want 0", n_err - eb); end
`else
        n_cmp++; if (n_err - eb < 1) begin n_fail++; $display("FAIL nofilter_err: got %0d want >=1", n_err - eb); end
`endif
        send_level(1'b0, 20);
    endtask

    initial begin
        test_reset();
        test_framed();
        test_back_to_back();
        test_boundary();
        test_glitch();
        test_loss();
        test_reset_mid();
        test_filter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
